// File: rtl/tt_vector_driver.sv
// Tiny Tapeout pin-interface checker: drives ui_in/rst_n/ena from a vector stream,
// samples uo_out LATENCY cycles after each drive edge and accumulates pass/fail stats.
module tt_vector_driver #(
  parameter int LATENCY    = 2,
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [7:0]       vec_stim,
  input  logic [7:0]       vec_expect,
  input  logic [7:0]       vec_mask,
  input  logic             vec_last,
  output logic [7:0]       dut_ui_in,
  output logic             dut_rst_n,
  output logic             dut_ena,
  input  logic [7:0]       dut_uo_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_DUT_RST, S_ACCEPT, S_WAIT, S_SAMPLE, S_DONE
  } state_t;

  localparam logic [7:0] RST_INIT  = 8'(RST_CYCLES - 1);
  localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

  state_t           state_q, state_d;
  logic [7:0]       ui_q, ui_d, expect_q, expect_d, mask_q, mask_d;
  logic             last_q, last_d, rst_n_q, rst_n_d, ena_q, ena_d;
  logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [7:0]       rcnt_q, rcnt_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d, ecnt_q, ecnt_d, ffi_q, ffi_d;
  logic             ffv_q, ffv_d;
  logic             mismatch;
  logic [CNT_W-1:0] ecnt_inc;

  assign mismatch = |((dut_uo_out ^ expect_q) & mask_q);
  assign ecnt_inc = (&ecnt_q) ? ecnt_q : ecnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    ui_d     = ui_q;
    expect_d = expect_q;
    mask_d   = mask_q;
    last_d   = last_q;
    rst_n_d  = rst_n_q;
    ena_d    = ena_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    rcnt_d   = rcnt_q;
    wcnt_d   = wcnt_q;
    vcnt_d   = vcnt_q;
    ecnt_d   = ecnt_q;
    ffi_d    = ffi_q;
    ffv_d    = ffv_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vcnt_d  = '0;
          ecnt_d  = '0;
          ffi_d   = '0;
          ffv_d   = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          ena_d   = 1'b1;
          rst_n_d = 1'b0;
          ui_d    = 8'h00;
          rcnt_d  = RST_INIT;
          state_d = S_DUT_RST;
        end
      end
      S_DUT_RST: begin
        if (rcnt_q == 8'd0) begin
          rst_n_d = 1'b1;
          ready_d = 1'b1;
          state_d = S_ACCEPT;
        end else begin
          rcnt_d = rcnt_q - 8'd1;
        end
      end
      S_ACCEPT: begin
        if (vec_valid && ready_q) begin
          ui_d     = vec_stim;
          expect_d = vec_expect;
          mask_d   = vec_mask;
          last_d   = vec_last;
          ready_d  = 1'b0;
          wcnt_d   = WAIT_INIT;
          state_d  = (LATENCY == 1) ? S_SAMPLE : S_WAIT;
        end
      end
      S_WAIT: begin
        // Leave on the edge where the counter would reach zero so the
        // SAMPLE edge lands exactly LATENCY edges after the handshake.
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        vcnt_d = vcnt_q + CNT_W'(1);
        if (mismatch) begin
          ecnt_d = ecnt_inc;
          if (!ffv_q) begin
            ffi_d = vcnt_q;
            ffv_d = 1'b1;
          end
        end
        if (last_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = !mismatch && (ecnt_q == '0);
          state_d = S_DONE;
        end else begin
          ready_d = 1'b1;
          state_d = S_ACCEPT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ui_q     <= 8'h00;
      expect_q <= 8'h00;
      mask_q   <= 8'h00;
      last_q   <= 1'b0;
      rst_n_q  <= 1'b0;
      ena_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      rcnt_q   <= 8'd0;
      wcnt_q   <= 4'd0;
      vcnt_q   <= '0;
      ecnt_q   <= '0;
      ffi_q    <= '0;
      ffv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ui_q     <= ui_d;
      expect_q <= expect_d;
      mask_q   <= mask_d;
      last_q   <= last_d;
      rst_n_q  <= rst_n_d;
      ena_q    <= ena_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      rcnt_q   <= rcnt_d;
      wcnt_q   <= wcnt_d;
      vcnt_q   <= vcnt_d;
      ecnt_q   <= ecnt_d;
      ffi_q    <= ffi_d;
      ffv_q    <= ffv_d;
    end
  end

  assign vec_ready        = ready_q;
  assign dut_ui_in        = ui_q;
  assign dut_rst_n        = rst_n_q;
  assign dut_ena          = ena_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign vec_count        = vcnt_q;
  assign err_count        = ecnt_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: doc/tt_vector_driver.md
Name: tt_vector_driver

Overview:
- Host-side counterpart of the Tiny Tapeout user-project pin interface: drives a DUT's ui_in/rst_n/ena pins and checks its uo_out against expected values.
- Consumes a stream of test vectors (stimulus, expected, mask) over a valid/ready handshake.
- Applies one vector at a time, samples the DUT after a fixed latency, and accumulates pass/fail statistics.
- Used in FPGA/emulation harnesses and as a synthesizable self-checker alongside tt_um_* projects.

Parameters:
- LATENCY, 2, cycles from the drive edge of dut_ui_in to the sample edge of dut_uo_out; legal range 1..15.
- RST_CYCLES, 4, cycles dut_rst_n is held low after start; legal range 1..255.
- CNT_W, 16, width of the vector and error counters.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run; ignored unless in IDLE or DONE.
- vec_valid  in  1  a vector is present on vec_*.
- vec_ready  out  1  driver accepts the vector this cycle.
- vec_stim  in  8  value to drive on dut_ui_in.
- vec_expect  in  8  expected dut_uo_out value.
- vec_mask  in  8  1 = compare this bit; 0 = don't care.
- vec_last  in  1  final vector of the run.
- dut_ui_in  out  8  to DUT ui_in.
- dut_rst_n  out  1  to DUT rst_n (active low).
- dut_ena  out  1  to DUT ena.
- dut_uo_out  in  8  from DUT uo_out.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next start.
- pass  out  1  valid when done: err_count == 0.
- vec_count  out  CNT_W  vectors completed.
- err_count  out  CNT_W  mismatching vectors; saturates at all-ones.
- first_fail_idx  out  CNT_W  index (0-based) of the first failing vector.
- first_fail_valid  out  1  first_fail_idx is meaningful.

Behaviour:
- Reset values: state = IDLE, dut_ui_in = 0, dut_rst_n = 0, dut_ena = 0, vec_ready = 0, busy = 0, done = 0, pass = 0, all counters = 0, first_fail_valid = 0.
- Asynchronous reset mid-run aborts immediately to these values.
- FSM states: IDLE, DUT_RST, ACCEPT, WAIT, SAMPLE, DONE.
- IDLE/DONE, start=1:
  - clear counters, first_fail_valid, done and pass;
  - set busy = 1, dut_ena = 1, dut_rst_n = 0, dut_ui_in = 0;
  - go to DUT_RST.
- DUT_RST: hold dut_rst_n = 0 for exactly RST_CYCLES cycles, then set dut_rst_n = 1 and go to ACCEPT.
- ACCEPT:
  - vec_ready = 1 (registered, asserted only in this state);
  - on vec_valid & vec_ready, latch expect, mask and last, and register vec_stim onto dut_ui_in;
  - go to WAIT with the wait counter set to LATENCY-1.
- Timing: a vector handshaken at edge t drives dut_ui_in after edge t; dut_uo_out is sampled at edge t+LATENCY.
- WAIT: decrement the counter; go to SAMPLE when it reaches 0. With LATENCY = 1 the FSM goes directly from ACCEPT to SAMPLE.
- SAMPLE:
  - mismatch = |((dut_uo_out ^ expect) & mask); mask = 0 never fails;
  - on mismatch: err_count += 1 (saturating); if first_fail_valid = 0, set first_fail_idx = vec_count and first_fail_valid = 1;
  - vec_count += 1 (wraps; not a fault);
  - if last, go to DONE, otherwise go to ACCEPT.
- Throughput: one vector per LATENCY+1 cycles.
- dut_ui_in holds the last stimulus until the next handshake or the next start.
- DONE: busy = 0, done = 1, pass = (err_count == 0); dut_ena stays 1 and dut_rst_n stays 1.
- A start during DUT_RST, ACCEPT, WAIT or SAMPLE is ignored.
- vec_valid outside ACCEPT is ignored; the producer must hold the vector until vec_ready.
- A start in the same cycle as the DONE transition is ignored; start is only sampled while the FSM is already in IDLE or DONE.

Test Plan:
- Reset, then start with RST_CYCLES=4 → dut_rst_n low for exactly 4 cycles, then high; busy=1; dut_ena=1; vec_ready rises on the next cycle.
- DUT modeled as uo_out = ui_in delayed by 2 cycles, LATENCY=2; 3 vectors stim 0x12/0x34/0x56 with matching expect, mask 0xFF, last on the third → done=1, pass=1, vec_count=3, err_count=0, one vector per 3 cycles.
- Same setup with vector 1 expect=0x35 and vector 2 expect=0x00 → err_count=2, first_fail_idx=1, first_fail_valid=1, pass=0.
- Vector stim 0xA5, expect 0x00, mask 0x00 → counted as pass; vector expect 0xA4, mask 0x01 → fail.
- vec_valid deasserted for 5 cycles in ACCEPT → dut_ui_in unchanged and no count change; start pulsed in WAIT → ignored.
- Assert rst during WAIT → all outputs return to reset values asynchronously (dut_rst_n=0, busy=0); a new start runs cleanly from vec_count=0.
